// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB writeback stage: load type codes,
// the default link offset and the layout of the pipeline register.
package wb_pkg;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    localparam int LINK_OFS_DEFAULT = 2;

    // The link address is computed at capture time so that a reset
    // register reads back as zero instead of 0 + LINK_OFS.
    typedef struct packed {
        logic        valid;
        logic        regwr;
        logic [4:0]  rw;
        logic [31:0] aluout;
        logic [31:0] dout;
        logic        memtoreg;
        logic [2:0]  ldtype;
        logic        link;
        logic [29:0] r31;
    } wb_reg_t;

endpackage

// File: rtl/wb_load_ext.sv
// Big-endian load data extraction and sign/zero extension, plus detection
// of misaligned halfword/word accesses (data still uses truncated alignment).
module wb_load_ext
    import wb_pkg::*;
(
    input  logic [31:0] Dout,
    input  logic [2:0]  LdType,
    input  logic [1:0]  ByteAddr,
    output logic [31:0] ext,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane 0 is the most significant byte.
    always_comb begin
        sel_byte = Dout[31:24];
        case (ByteAddr)
            2'd1:    sel_byte = Dout[23:16];
            2'd2:    sel_byte = Dout[15:8];
            2'd3:    sel_byte = Dout[7:0];
            default: sel_byte = Dout[31:24];
        endcase
        sel_half = ByteAddr[1] ? Dout[15:0] : Dout[31:16];
    end

    always_comb begin
        ext      = Dout;
        misalign = 1'b0;
        case (LdType)
            LD_W:  misalign = (ByteAddr != 2'b00);
            LD_B:  ext = {{24{sel_byte[7]}}, sel_byte};
            LD_BU: ext = {24'h000000, sel_byte};
            LD_H: begin
                ext      = {{16{sel_half[15]}}, sel_half};
                misalign = ByteAddr[0];
            end
            LD_HU: begin
                ext      = {16'h0000, sel_half};
                misalign = ByteAddr[0];
            end
            default: ext = Dout;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and register-file write-side logic.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int LINK_OFS = LINK_OFS_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        mem_valid,
    input  logic        mem_RegWr,
    input  logic [4:0]  mem_Rw,
    input  logic [31:0] mem_ALUout,
    input  logic [31:0] mem_Dout,
    input  logic        mem_MemtoReg,
    input  logic [2:0]  mem_LdType,
    input  logic        mem_Link,
    input  logic [29:0] mem_PC,
    input  logic        wb_stall,
    input  logic        wb_flush,
    output logic        WrEn,
    output logic [4:0]  Rw,
    output logic [31:0] busW,
    output logic        R31Wr,
    output logic [29:0] R31,
    output logic        wb_valid,
    output logic [31:0] fwd_busW,
    output logic        misalign
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    wb_reg_t     cap, q;
    logic [31:0] ld_data;
    logic        ld_misalign;
    logic        cur_misalign;
    logic        misalign_q;

    always_comb begin
        cap          = '0;
        cap.valid    = mem_valid & ~wb_flush;
        cap.regwr    = mem_RegWr;
        cap.rw       = mem_Rw;
        cap.aluout   = mem_ALUout;
        cap.dout     = mem_Dout;
        cap.memtoreg = mem_MemtoReg;
        cap.ldtype   = mem_LdType;
        cap.link     = mem_Link;
        cap.r31      = mem_PC + 30'(LINK_OFS);
    end

    // Flush overrides stall so a stalled slot can still be turned into a bubble.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= '0;
        end else if (wb_flush || !wb_stall) begin
            q <= cap;
        end
    end

    wb_load_ext u_load_ext (
        .Dout     (q.dout),
        .LdType   (q.ldtype),
        .ByteAddr (q.aluout[1:0]),
        .ext      (ld_data),
        .misalign (ld_misalign)
    );

    assign wb_valid     = q.valid;
    assign Rw           = q.rw;
    assign R31          = q.r31;
    assign R31Wr        = q.valid & q.link;
    assign WrEn         = q.valid & q.regwr & ~q.link & (q.rw != 5'd0);
    assign busW         = q.link ? {q.r31, 2'b00} : (q.memtoreg ? ld_data : q.aluout);
    assign fwd_busW     = busW;
    assign cur_misalign = q.valid & q.memtoreg & ~q.link & ld_misalign;
    assign misalign     = misalign_q | cur_misalign;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            misalign_q <= 1'b0;
        end else if (cur_misalign) begin
            misalign_q <= 1'b1;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            retire_cnt <= 32'd0;
        end else if (q.valid && !wb_stall) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written
// stall/flush/reset/misalign sequences and randomized traffic against a model.
module tb_wb_stage;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef struct {
        logic        valid;
        logic        regwr;
        logic [4:0]  rw;
        logic [31:0] aluout;
        logic [31:0] dout;
        logic        memtoreg;
        logic [2:0]  ldtype;
        logic        link;
        logic [29:0] pc;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic [31:0] exp_busw;
        logic        exp_wren;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        mem_valid, mem_RegWr, mem_MemtoReg, mem_Link;
    logic [4:0]  mem_Rw;
    logic [31:0] mem_ALUout, mem_Dout;
    logic [2:0]  mem_LdType;
    logic [29:0] mem_PC;
    logic        wb_stall, wb_flush;
    logic        WrEn, R31Wr, wb_valid, misalign;
    logic [4:0]  Rw;
    logic [31:0] busW, fwd_busW;
    logic [29:0] R31;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int total = 0;
    int bad   = 0;

    instr_t      m_wb;
    bit          m_reset;
    bit          m_seen_mis;
    logic [31:0] m_cnt;

    wb_stage dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .mem_valid    (mem_valid),
        .mem_RegWr    (mem_RegWr),
        .mem_Rw       (mem_Rw),
        .mem_ALUout   (mem_ALUout),
        .mem_Dout     (mem_Dout),
        .mem_MemtoReg (mem_MemtoReg),
        .mem_LdType   (mem_LdType),
        .mem_Link     (mem_Link),
        .mem_PC       (mem_PC),
        .wb_stall     (wb_stall),
        .wb_flush     (wb_flush),
        .WrEn         (WrEn),
        .Rw           (Rw),
        .busW         (busW),
        .R31Wr        (R31Wr),
        .R31          (R31),
        .wb_valid     (wb_valid),
        .fwd_busW     (fwd_busW),
        .misalign     (misalign)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt   (retire_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic instr_t mk(logic v, logic rwr, logic [4:0] rw, logic [31:0] alu,
                                  logic [31:0] d, logic m2r, logic [2:0] lt, logic lnk,
                                  logic [29:0] pc);
        instr_t i;
        i.valid = v; i.regwr = rwr; i.rw = rw; i.aluout = alu; i.dout = d;
        i.memtoreg = m2r; i.ldtype = lt; i.link = lnk; i.pc = pc;
        return i;
    endfunction

    // Byte/halfword picked arithmetically by shifting; sign handled by subtraction.
    function automatic logic [31:0] load_val(logic [31:0] d, logic [2:0] lt, logic [1:0] a);
        logic [31:0] b, h;
        b = (d >> (8 * (3 - int'(a)))) & 32'hFF;
        h = a[1] ? (d & 32'hFFFF) : (d >> 16);
        case (lt)
            LD_B:    return (b >= 128) ? b - 32'd256 : b;
            LD_BU:   return b;
            LD_H:    return (h >= 32768) ? h - 32'd65536 : h;
            LD_HU:   return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_busw(instr_t i);
        if (i.link) return {i.pc + 30'd2, 2'b00};
        if (i.memtoreg) return load_val(i.dout, i.ldtype, i.aluout[1:0]);
        return i.aluout;
    endfunction

    function automatic bit is_misaligned(instr_t i);
        if (!i.valid || !i.memtoreg || i.link) return 0;
        if (i.ldtype == LD_W) return i.aluout[1:0] != 2'b00;
        if (i.ldtype == LD_H || i.ldtype == LD_HU) return i.aluout[0];
        return 0;
    endfunction

    task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wb       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset    = 1;
        m_seen_mis = 0;
        m_cnt      = 0;
    endtask

    // Drive one MEM slot, clock it, advance the model, then sample 1 ns later.
    task automatic applyStimulus(instr_t i, logic stall, logic flush);
        mem_valid = i.valid; mem_RegWr = i.regwr; mem_Rw = i.rw;
        mem_ALUout = i.aluout; mem_Dout = i.dout; mem_MemtoReg = i.memtoreg;
        mem_LdType = i.ldtype; mem_Link = i.link; mem_PC = i.pc;
        wb_stall = stall; wb_flush = flush;
        @(posedge Clk);
        if (m_wb.valid && !stall) m_cnt++;
        if (flush || !stall) begin
            m_wb = i;
            m_reset = 0;
            if (flush) m_wb.valid = 0;
        end
        if (is_misaligned(m_wb)) m_seen_mis = 1;
        #1;
    endtask

    task automatic checkOutput(string tag);
        bit v;
        v = m_wb.valid;
        compare({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, v});
        compare({tag, ".WrEn"}, {31'd0, WrEn},
                {31'd0, v && m_wb.regwr && !m_wb.link && m_wb.rw != 0});
        compare({tag, ".R31Wr"}, {31'd0, R31Wr}, {31'd0, v && m_wb.link});
        compare({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_seen_mis});
        if (m_reset) begin
            compare({tag, ".busW_rst"}, busW, 32'd0);
            compare({tag, ".Rw_rst"}, {27'd0, Rw}, 32'd0);
            compare({tag, ".R31_rst"}, {2'd0, R31}, 32'd0);
        end else if (v) begin
            compare({tag, ".busW"}, busW, exp_busw(m_wb));
            compare({tag, ".fwd_busW"}, fwd_busW, exp_busw(m_wb));
            compare({tag, ".Rw"}, {27'd0, Rw}, {27'd0, m_wb.rw});
            if (m_wb.link) compare({tag, ".R31"}, {2'd0, R31}, {2'd0, m_wb.pc + 30'd2});
        end
`ifdef WB_RETIRE_CNT_EN
        compare({tag, ".retire_cnt"}, retire_cnt, m_cnt);
`endif
    endtask

    // Reset is pulsed between clock edges, checked while still asserted.
    task automatic doReset(string tag);
        @(negedge Clk);
        #2 Reset = 1'b1;
        model_reset();
        #1 checkOutput(tag);
        #1 Reset = 1'b0;
    endtask

    instr_t bubble;
    vec_t   vecs[10];
    instr_t r;

    initial begin
        bubble = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        mem_valid = 0; mem_RegWr = 0; mem_Rw = 0; mem_ALUout = 0; mem_Dout = 0;
        mem_MemtoReg = 0; mem_LdType = 0; mem_Link = 0; mem_PC = 0;
        wb_stall = 0; wb_flush = 0;
        model_reset();
        #1 checkOutput("power_on_reset");
        doReset("reset");

        vecs[0] = '{mk(1, 1, 8, 32'h5, 0, 0, LD_W, 0, 30'h40), 32'h0000_0005, 1'b1};
        vecs[1] = '{mk(1, 1, 3, 32'h1000, 32'h80FF_7F01, 1, LD_B, 0, 0), 32'hFFFF_FF80, 1'b1};
        vecs[2] = '{mk(1, 1, 3, 32'h1001, 32'h80FF_7F01, 1, LD_BU, 0, 0), 32'h0000_00FF, 1'b1};
        vecs[3] = '{mk(1, 1, 3, 32'h1002, 32'h80FF_7F01, 1, LD_H, 0, 0), 32'h0000_7F01, 1'b1};
        vecs[4] = '{mk(1, 1, 3, 32'h1000, 32'h80FF_7F01, 1, LD_HU, 0, 0), 32'h0000_80FF, 1'b1};
        vecs[5] = '{mk(1, 0, 0, 32'h9, 0, 1, LD_B, 1, 30'h100), 32'h0000_0408, 1'b0};
        vecs[6] = '{mk(1, 1, 31, 32'h9, 0, 0, LD_W, 1, 30'h100), 32'h0000_0408, 1'b0};
        vecs[7] = '{mk(1, 1, 0, 32'h77, 0, 0, LD_W, 0, 0), 32'h0000_0077, 1'b0};
        vecs[8] = '{mk(1, 1, 4, 32'h1004, 32'hDEAD_BEEF, 1, LD_W, 0, 0), 32'hDEAD_BEEF, 1'b1};
        vecs[9] = '{mk(1, 1, 5, 32'h1003, 32'h1234_5678, 1, 3'd7, 0, 0), 32'h1234_5678, 1'b1};

        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k].in, 0, 0);
            compare($sformatf("vec%0d.busW", k), busW, vecs[k].exp_busw);
            compare($sformatf("vec%0d.WrEn", k), {31'd0, WrEn}, {31'd0, vecs[k].exp_wren});
            checkOutput($sformatf("vec%0d", k));
            @(negedge Clk);
        end

        // Stall holds an Rw=9 write while different MEM contents are presented.
        applyStimulus(mk(1, 1, 9, 32'hABCD, 0, 0, LD_W, 0, 0), 0, 0);
        checkOutput("stall_load");
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            applyStimulus(mk(1, 1, 12, 32'h1111, 0, 0, LD_W, 0, 0), 1, 0);
            compare($sformatf("stall%0d.WrEn", k), {31'd0, WrEn}, 32'd1);
            compare($sformatf("stall%0d.Rw", k), {27'd0, Rw}, 32'd9);
            checkOutput($sformatf("stall%0d", k));
        end

        @(negedge Clk);
        applyStimulus(mk(1, 1, 7, 32'h2, 0, 0, LD_W, 0, 0), 1, 1);
        compare("flush_stall.wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("flush_stall");

        // Reset while a write is being presented.
        @(negedge Clk);
        applyStimulus(mk(1, 1, 6, 32'h66, 0, 0, LD_W, 0, 0), 0, 0);
        compare("pre_reset.WrEn", {31'd0, WrEn}, 32'd1);
        doReset("mid_reset");
        compare("mid_reset.WrEn", {31'd0, WrEn}, 32'd0);

        // Misaligned word load sets the sticky flag until the next reset.
        applyStimulus(mk(1, 1, 10, 32'h2002, 32'h5555_AAAA, 1, LD_W, 0, 0), 0, 0);
        compare("misalign_set", {31'd0, misalign}, 32'd1);
        checkOutput("misalign_ld");
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            applyStimulus(bubble, 0, 0);
            compare($sformatf("misalign_sticky%0d", k), {31'd0, misalign}, 32'd1);
        end
        doReset("misalign_reset");
        compare("misalign_cleared", {31'd0, misalign}, 32'd0);

        // Five retirements with a two-cycle stall and one bubble in between.
        applyStimulus(mk(1, 1, 1, 1, 0, 0, LD_W, 0, 0), 0, 0); @(negedge Clk);
        applyStimulus(mk(1, 1, 2, 2, 0, 0, LD_W, 0, 0), 0, 0); @(negedge Clk);
        applyStimulus(mk(1, 1, 3, 3, 0, 0, LD_W, 0, 0), 1, 0); @(negedge Clk);
        applyStimulus(mk(1, 1, 3, 3, 0, 0, LD_W, 0, 0), 1, 0); @(negedge Clk);
        applyStimulus(mk(1, 1, 3, 3, 0, 0, LD_W, 0, 0), 0, 0); @(negedge Clk);
        applyStimulus(bubble, 0, 0); @(negedge Clk);
        applyStimulus(mk(1, 1, 4, 4, 0, 0, LD_W, 0, 0), 0, 0); @(negedge Clk);
        applyStimulus(mk(1, 1, 5, 5, 0, 0, LD_W, 0, 0), 0, 0); @(negedge Clk);
        applyStimulus(bubble, 0, 0); @(negedge Clk);
        applyStimulus(bubble, 0, 0);
        checkOutput("retire_seq");
`ifdef WB_RETIRE_CNT_EN
        compare("retire_cnt_five", retire_cnt, 32'd5);
`endif

        // Randomized traffic with random stalls and flushes.
        for (int k = 0; k < 300; k++) begin
            @(negedge Clk);
            r = mk($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom),
                   $urandom, $urandom, 1'($urandom), 3'($urandom),
                   $urandom_range(0, 4) == 0, 30'($urandom));
            applyStimulus(r, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            checkOutput($sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
